// File: rtl/led_gpio_pkg.sv
// Shared definitions for the LED/button bus responder: register offsets,
// window size and transaction FSM states.
package led_gpio_pkg;

   localparam logic [4:0] OFF_LED_DATA   = 5'h00;
   localparam logic [4:0] OFF_LED_SET    = 5'h04;
   localparam logic [4:0] OFF_LED_CLR    = 5'h08;
   localparam logic [4:0] OFF_BTN_IN     = 5'h0C;
   localparam logic [4:0] OFF_BTN_EDGE   = 5'h10;
   localparam logic [4:0] OFF_BLINK_MASK = 5'h14;
   localparam logic [4:0] OFF_BLINK_DIV  = 5'h18;

   localparam int unsigned WIN_SIZE = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

endpackage

// File: rtl/led_gpio_responder_btn_sync.sv
// Two-flop button synchronizer with rising-edge detect on the synchronized level.
module btn_sync_edge #(
   parameter int unsigned BTN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BTN_W-1:0] i_btn,
   output logic [BTN_W-1:0] o_level,
   output logic [BTN_W-1:0] o_rise
);

   logic [BTN_W-1:0] r_s1;
   logic [BTN_W-1:0] r_s2;
   logic [BTN_W-1:0] r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_prev <= '0;
      end else begin
         r_s1   <= i_btn;
         r_s2   <= r_s1;
         r_prev <= r_s2;
      end
   end

   assign o_level = r_s2;
   assign o_rise  = r_s2 & ~r_prev;

endmodule

// File: rtl/led_gpio_responder.sv
// Memory-mapped LED/button responder with programmable wait states.
// Optional blink unit (BLINK_MASK/BLINK_DIV) enabled by defining LED_BLINK_EN.
module led_gpio_responder
   import led_gpio_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned BTN_W       = 4,
   parameter logic [7:0]  LED_RESET   = 8'h00
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bus_req,
   input  logic             bus_we,
   input  logic [31:0]      bus_addr,
   input  logic [31:0]      bus_wdata,
   input  logic [3:0]       bus_wstrb,
   output logic             bus_ack,
   output logic [31:0]      bus_rdata,
   output logic             bus_err,
   input  logic [BTN_W-1:0] btn_in,
   output logic [7:0]       leds
);

   localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_t           r_state;
   state_t           w_next;
   logic [3:0]       r_cnt;
   logic             r_we;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic             r_wstrb0;
   logic [7:0]       r_led;
   logic [BTN_W-1:0] r_edge;
   logic             r_ack;
   logic             r_err;
   logic [31:0]      r_rdata;

   logic [BTN_W-1:0] w_level;
   logic [BTN_W-1:0] w_rise;
   logic [BTN_W-1:0] w_edge_clr;
   logic [31:0]      w_off;
   logic             w_in_win;
   logic             w_err;
   logic [31:0]      w_rdata;
   logic             w_wr;
   logic             w_unused;

`ifdef LED_BLINK_EN
   logic [7:0]  r_blink_mask;
   logic [15:0] r_blink_div;
   logic [15:0] r_blink_cnt;
   logic        r_phase;
`endif

   btn_sync_edge #(.BTN_W(BTN_W)) u_btn (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn_in),
      .o_level (w_level),
      .o_rise  (w_rise)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus_req) w_next = (WAIT_STATES != 0) ? WAIT : ACK;
         WAIT:    if (r_cnt == 4'd0) w_next = ACK;
         ACK:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wstrb0 <= 1'b0;
      end else if (r_state == IDLE && bus_req) begin
         r_cnt    <= WS_LOAD;
         r_we     <= bus_we;
         r_addr   <= bus_addr;
         r_wdata  <= bus_wdata;
         r_wstrb0 <= bus_wstrb[0];
      end else if (r_state == WAIT) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Unsigned offset wraps for addresses below the base, so the explicit
   // lower bound is kept for clarity rather than necessity.
   assign w_off    = r_addr - ADDR_BASE;
   assign w_in_win = (r_addr >= ADDR_BASE) && (w_off < WIN_SIZE);

   always_comb begin
      w_err   = 1'b0;
      w_rdata = '0;
      if (!w_in_win || r_addr[1:0] != 2'b00) begin
         w_err = 1'b1;
      end else begin
         case (w_off[4:0])
            OFF_LED_DATA:   w_rdata[7:0] = r_led;
            OFF_LED_SET:    ;
            OFF_LED_CLR:    ;
            OFF_BTN_IN:     if (r_we) w_err = 1'b1;
                            else      w_rdata[BTN_W-1:0] = w_level;
            OFF_BTN_EDGE:   w_rdata[BTN_W-1:0] = r_edge;
`ifdef LED_BLINK_EN
            OFF_BLINK_MASK: w_rdata[7:0]  = r_blink_mask;
            OFF_BLINK_DIV:  w_rdata[15:0] = r_blink_div;
`endif
            default:        w_err = 1'b1;
         endcase
      end
   end

   assign w_wr       = (r_state == ACK) && r_we && r_wstrb0 && !w_err;
   assign w_edge_clr = (w_wr && w_off[4:0] == OFF_BTN_EDGE) ? r_wdata[BTN_W-1:0] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_led   <= LED_RESET;
         r_edge  <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack <= (r_state == ACK);
         if (r_state == ACK) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_we) ? '0 : w_rdata;
         end else begin
            r_err   <= 1'b0;
            r_rdata <= '0;
         end
         if (w_wr) begin
            case (w_off[4:0])
               OFF_LED_DATA: r_led <= r_wdata[7:0];
               OFF_LED_SET:  r_led <= r_led | r_wdata[7:0];
               OFF_LED_CLR:  r_led <= r_led & ~r_wdata[7:0];
               default:      ;
            endcase
         end
         // A fresh rise outranks a same-cycle clear of that bit.
         r_edge <= (r_edge & ~w_edge_clr) | w_rise;
      end
   end

`ifdef LED_BLINK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blink_mask <= '0;
         r_blink_div  <= 16'hFFFF;
         r_blink_cnt  <= '0;
         r_phase      <= 1'b0;
      end else begin
         if (r_blink_cnt == r_blink_div) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 16'd1;
         end
         if (w_wr && w_off[4:0] == OFF_BLINK_MASK) r_blink_mask <= r_wdata[7:0];
         if (w_wr && w_off[4:0] == OFF_BLINK_DIV)  r_blink_div  <= r_wdata[15:0];
      end
   end

   assign leds = r_led ^ (r_blink_mask & {8{r_phase}});
`else
   assign leds = r_led;
`endif

   assign bus_ack   = r_ack;
   assign bus_err   = r_err;
   assign bus_rdata = r_rdata;
   assign w_unused  = ^{bus_wstrb[3:1], r_wdata};

endmodule

// File: tb/tb_led_gpio_responder.sv
// Self-checking bench for led_gpio_responder (default build, WAIT_STATES=1).
module tb_led_gpio_responder;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int          WS   = 1;
   localparam logic [7:0]  LRST = 8'h00;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ack, bus_err;
   logic [31:0] bus_rdata;
   logic [3:0]  btn_in;
   logic [7:0]  leds;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   led_gpio_responder #(
      .ADDR_BASE   (BASE),
      .WAIT_STATES (WS),
      .BTN_W       (4),
      .LED_RESET   (LRST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_wstrb (bus_wstrb),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .bus_err   (bus_err),
      .btn_in    (btn_in),
      .leds      (leds)
   );

   // Reference model: transaction completes WS+1 edges after capture; buttons
   // become visible two edges after sampling, and edges are sticky.
   logic [7:0]  m_led;
   logic [3:0]  m_edge, m_clr, m_rise;
   logic [3:0]  h1, h2, h3;
   logic        m_busy, m_ack, m_err;
   int          m_left;
   logic [31:0] m_rdata;
   logic        t_we, t_st;
   logic [31:0] t_addr, t_wd, t_off;

   task automatic model_respond();
      m_err   = 1'b0;
      m_rdata = '0;
      m_clr   = '0;
      t_off   = t_addr - BASE;
      if (t_addr < BASE || t_addr >= BASE + 32 || t_addr[1:0] != 2'b00) begin
         m_err = 1'b1;
      end else begin
         case (t_off)
            32'h00: begin m_rdata = {24'h0, m_led}; if (t_we && t_st) m_led = t_wd[7:0]; end
            32'h04: if (t_we && t_st) m_led = m_led | t_wd[7:0];
            32'h08: if (t_we && t_st) m_led = m_led & ~t_wd[7:0];
            32'h0C: if (t_we) m_err = 1'b1; else m_rdata = {28'h0, h2};
            32'h10: begin m_rdata = {28'h0, m_edge}; if (t_we && t_st) m_clr = t_wd[3:0]; end
            default: m_err = 1'b1;
         endcase
      end
      if (m_err || t_we) m_rdata = '0;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_led = LRST; m_edge = '0; m_busy = 1'b0; m_ack = 1'b0; m_err = 1'b0;
         m_rdata = '0; m_left = 0; h1 = '0; h2 = '0; h3 = '0;
      end else begin
         m_rise = h2 & ~h3;
         m_clr  = '0;
         m_ack  = 1'b0;
         if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               model_respond();
               m_ack  = 1'b1;
               m_busy = 1'b0;
            end
         end else if (bus_req) begin
            m_busy = 1'b1; m_left = WS + 1;
            t_we = bus_we; t_addr = bus_addr; t_wd = bus_wdata; t_st = bus_wstrb[0];
         end
         m_edge = (m_edge & ~m_clr) | m_rise;
         h3 = h2; h2 = h1; h1 = btn_in;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         n_cmp++;
         if (leds !== m_led) begin
            n_bad++; $display("FAIL leds t=%0t got=%h exp=%h", $time, leds, m_led);
         end
         n_cmp++;
         if (bus_ack !== m_ack) begin
            n_bad++; $display("FAIL ack t=%0t got=%b exp=%b", $time, bus_ack, m_ack);
         end
         n_cmp++;
         if (bus_err !== (m_ack & m_err)) begin
            n_bad++; $display("FAIL err t=%0t got=%b exp=%b", $time, bus_err, m_ack & m_err);
         end
         if (m_ack) begin
            n_cmp++;
            if (bus_rdata !== m_rdata) begin
               n_bad++; $display("FAIL rdata t=%0t got=%h exp=%h", $time, bus_rdata, m_rdata);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++; $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit use_b, input logic [3:0] bset,
                      output logic [31:0] rd, output logic er, output int lat);
      @(negedge clk);
      bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd; bus_wstrb = st;
      if (use_b) btn_in = bset;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus_ack) begin lat = k; break; end
      end
      if (lat == 0) begin
         n_cmp++; n_bad++; $display("FAIL ack_timeout addr=%h got=no_ack exp=ack", a);
      end
      rd = bus_rdata; er = bus_err;
      bus_req = 1'b0; bus_we = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;

   initial begin
      rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
      bus_wstrb = '0; btn_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_leds", {24'h0, leds}, 32'h0000_0000);
      chk("reset_ack", {31'h0, bus_ack}, 32'h0);
      rst = 1'b0;

      // basic write/read with latency
      txn(1'b1, 32'h1000, 32'h0000_00A5, 4'h1, 1'b0, 4'h0, rd, er, lat);
      chk("wr_lat", lat, 32'd3);
      chk("wr_err", {31'h0, er}, 32'h0);
      chk("wr_leds", {24'h0, leds}, 32'h0000_00A5);
      txn(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("rd_led", rd, 32'h0000_00A5);

      // set/clear
      txn(1'b1, 32'h1000, 32'h0000_000F, 4'h1, 1'b0, 4'h0, rd, er, lat);
      txn(1'b1, 32'h1004, 32'h0000_00F0, 4'h1, 1'b0, 4'h0, rd, er, lat);
      chk("set_leds", {24'h0, leds}, 32'h0000_00FF);
      txn(1'b1, 32'h1008, 32'h0000_0003, 4'h1, 1'b0, 4'h0, rd, er, lat);
      chk("clr_leds", {24'h0, leds}, 32'h0000_00FC);
      txn(1'b0, 32'h1004, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("rd_set", rd, 32'h0);
      txn(1'b0, 32'h1008, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("rd_clr", rd, 32'h0);
      txn(1'b1, 32'h1000, 32'h0000_0011, 4'hE, 1'b0, 4'h0, rd, er, lat);
      chk("nostrb_leds", {24'h0, leds}, 32'h0000_00FC);
      chk("nostrb_err", {31'h0, er}, 32'h0);

      // buttons
      @(negedge clk); btn_in = 4'b0101;
      repeat (3) @(negedge clk);
      txn(1'b0, 32'h100C, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("btn_in", rd, 32'h5);
      txn(1'b0, 32'h1010, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("btn_edge", rd, 32'h5);
      txn(1'b1, 32'h1010, 32'h1, 4'h1, 1'b0, 4'h0, rd, er, lat);
      txn(1'b0, 32'h1010, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("edge_w1c", rd, 32'h4);
      @(negedge clk); btn_in = 4'b0000;
      repeat (4) @(negedge clk);
      txn(1'b1, 32'h1010, 32'h1, 4'h1, 1'b1, 4'b0001, rd, er, lat);
      txn(1'b0, 32'h1010, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("edge_wins", rd, 32'h5);

      // error cases
      txn(1'b0, 32'h2000, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("oow_err", {31'h0, er}, 32'h1);
      chk("oow_rd", rd, 32'h0);
      txn(1'b1, 32'h100C, 32'hFF, 4'h1, 1'b0, 4'h0, rd, er, lat);
      chk("ro_err", {31'h0, er}, 32'h1);
      txn(1'b0, 32'h1002, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("mis_err", {31'h0, er}, 32'h1);
      chk("mis_rd", rd, 32'h0);
      txn(1'b1, 32'h0FFC, 32'h00, 4'h1, 1'b0, 4'h0, rd, er, lat);
      chk("below_err", {31'h0, er}, 32'h1);
      txn(1'b0, 32'h101C, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("rsv_err", {31'h0, er}, 32'h1);
`ifndef LED_BLINK_EN
      txn(1'b0, 32'h1014, 32'h0, 4'h0, 1'b0, 4'h0, rd, er, lat);
      chk("blink_rsv_err", {31'h0, er}, 32'h1);
`endif
      chk("err_leds", {24'h0, leds}, 32'h0000_00FC);

      // reset during WAIT
      @(negedge clk);
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = 32'h1000; bus_wdata = 32'h55; bus_wstrb = 4'h1;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ack", {31'h0, bus_ack}, 32'h0);
      chk("rst_leds", {24'h0, leds}, {24'h0, LRST});
      bus_req = 1'b0; bus_we = 1'b0;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_rst_leds", {24'h0, leds}, {24'h0, LRST});
      txn(1'b1, 32'h1000, 32'h0000_003C, 4'h1, 1'b0, 4'h0, rd, er, lat);
      chk("post_rst_lat", lat, 32'd3);
      chk("post_rst_wr", {24'h0, leds}, 32'h0000_003C);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
